// File: rtl/mcu_image_writer.sv
// rtl/mcu_image_writer.sv - writes decoded EDGE x EDGE blocks into a raster-order frame RAM
// One hold buffer accepts the next block while the work buffer streams one pixel per cycle.
module mcu_image_writer #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int PIXEL_WIDTH  = 8,
  parameter int CHANNELS     = 3,
  parameter int EDGE         = 8,
  parameter int ADDR_WIDTH   = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [EDGE*EDGE*CHANNELS*PIXEL_WIDTH-1:0] blk_data,
  input  logic                                      blk_valid,
  output logic                                      blk_ready,
  input  logic                                      frame_restart,
  output logic [ADDR_WIDTH-1:0]                     ram_addr,
  output logic [CHANNELS*PIXEL_WIDTH-1:0]           ram_data,
  output logic                                      ram_we,
  output logic                                      busy,
  output logic                                      block_done,
  output logic                                      frame_done,
  output logic [((IMAGE_WIDTH/EDGE) > 1 ? $clog2(IMAGE_WIDTH/EDGE) : 1)-1:0]   block_x,
  output logic [((IMAGE_HEIGHT/EDGE) > 1 ? $clog2(IMAGE_HEIGHT/EDGE) : 1)-1:0] block_y
);

  localparam int PIX_W    = CHANNELS * PIXEL_WIDTH;
  localparam int NPIX     = EDGE * EDGE;
  localparam int BX_W     = (IMAGE_WIDTH/EDGE) > 1 ? $clog2(IMAGE_WIDTH/EDGE) : 1;
  localparam int BY_W     = (IMAGE_HEIGHT/EDGE) > 1 ? $clog2(IMAGE_HEIGHT/EDGE) : 1;
  localparam int CNT_W    = EDGE > 1 ? $clog2(EDGE) : 1;
  localparam logic [BX_W-1:0]       BX_LAST  = BX_W'(IMAGE_WIDTH/EDGE - 1);
  localparam logic [BY_W-1:0]       BY_LAST  = BY_W'(IMAGE_HEIGHT/EDGE - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(EDGE - 1);
  localparam logic [ADDR_WIDTH-1:0] EDGE_A   = ADDR_WIDTH'(EDGE);
  localparam logic [ADDR_WIDTH-1:0] WIDTH_A  = ADDR_WIDTH'(IMAGE_WIDTH);

  if (EDGE < 1 || (EDGE & (EDGE - 1)) != 0 || (IMAGE_WIDTH % EDGE) != 0 ||
      (IMAGE_HEIGHT % EDGE) != 0 || CHANNELS < 1 || CHANNELS > 4) begin : g_bad_params
    $error("mcu_image_writer: illegal parameter set");
  end

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                       state, state_next;
  logic [NPIX*PIX_W-1:0]        hold_buf;
  logic [PIX_W-1:0]             work_buf [NPIX];
  logic                         hold_full;
  logic [CNT_W-1:0]             r, c;
  logic                         accept, load_work, last_pixel, last_block;
  logic [2*CNT_W-1:0]           pix_idx;
  logic [ADDR_WIDTH-1:0]        row_a, col_a, pix_addr;

  assign blk_ready  = !hold_full && !frame_restart;
  assign accept     = blk_valid && blk_ready;
  assign last_pixel = (state == WRITE) && (r == CNT_LAST) && (c == CNT_LAST);
  assign last_block = (block_x == BX_LAST) && (block_y == BY_LAST);
  assign busy       = (state == WRITE) || hold_full;

  always_comb begin
    state_next = state;
    load_work  = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          state_next = WRITE;
          load_work  = 1'b1;
        end
      end
      WRITE: begin
        if (last_pixel) begin
          // A waiting block is chained straight in so the RAM sees no bubble.
          if (hold_full) load_work = 1'b1;
          else           state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (frame_restart) begin
      state_next = IDLE;
      load_work  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst || frame_restart) begin
      hold_full  <= 1'b0;
      r          <= '0;
      c          <= '0;
      block_x    <= '0;
      block_y    <= '0;
      block_done <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      block_done <= last_pixel;
      frame_done <= last_pixel && last_block;
      if (accept)         hold_full <= 1'b1;
      else if (load_work) hold_full <= 1'b0;
      if (state == IDLE) begin
        r <= '0;
        c <= '0;
      end else begin
        c <= (c == CNT_LAST) ? '0 : c + 1'b1;
        if (c == CNT_LAST) r <= (r == CNT_LAST) ? '0 : r + 1'b1;
      end
      if (last_pixel) begin
        if (block_x == BX_LAST) begin
          block_x <= '0;
          block_y <= (block_y == BY_LAST) ? '0 : block_y + 1'b1;
        end else begin
          block_x <= block_x + 1'b1;
        end
      end
    end
  end

  // Buffer contents need no reset: hold_full and the FSM decide what is live.
  always_ff @(posedge clk) begin
    if (accept) hold_buf <= blk_data;
    if (load_work) begin
      for (int i = 0; i < NPIX; i++) work_buf[i] <= hold_buf[i*PIX_W +: PIX_W];
    end
  end

  // EDGE is a power of two, so r*EDGE+c is just the concatenation.
  assign pix_idx  = {r, c};
  assign row_a    = ADDR_WIDTH'(block_y) * EDGE_A + ADDR_WIDTH'(r);
  assign col_a    = ADDR_WIDTH'(block_x) * EDGE_A + ADDR_WIDTH'(c);
  assign pix_addr = row_a * WIDTH_A + col_a;

  assign ram_we   = (state == WRITE);
  assign ram_addr = ram_we ? pix_addr : '0;
  assign ram_data = ram_we ? work_buf[pix_idx] : '0;

endmodule
